// File: rtl/apb_node_timeout.sv
// One-to-N APB interconnect node: registered request stage, lowest-index address decode,
// built-in error response for unmapped addresses and a watchdog that aborts hung slaves.
module apb_node_timeout #(
    parameter int                             NB_SLAVES      = 11,
    parameter int                             ADDR_WIDTH     = 32,
    parameter int                             DATA_WIDTH     = 32,
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] START_ADDR    = {NB_SLAVES{32'h0}},
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] END_ADDR      = {NB_SLAVES{32'h0}},
    parameter int                             TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0]          ERR_RDATA      = 32'hBADA_CCE5
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [ADDR_WIDTH-1:0]           paddr_i,
    input  logic [DATA_WIDTH-1:0]           pwdata_i,
    input  logic                            pwrite_i,
    input  logic                            psel_i,
    input  logic                            penable_i,
    output logic [DATA_WIDTH-1:0]           prdata_o,
    output logic                            pready_o,
    output logic                            pslverr_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic [DATA_WIDTH-1:0]           pwdata_o,
    output logic                            pwrite_o,
    output logic                            penable_o,
    output logic [NB_SLAVES-1:0]            psel_o,
    input  logic [NB_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVES-1:0]            pready_i,
    input  logic [NB_SLAVES-1:0]            pslverr_i,
    output logic                            timeout_o,
    output logic [15:0]                     err_cnt_o
);

    localparam int SEL_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    // Handshake: upstream request is a setup phase (psel_i=1, penable_i=0) seen in IDLE;
    // downstream completes on pready_i of the selected slave while penable_o=1;
    // upstream completes on the single DONE cycle where pready_o=1.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [SEL_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  timeout_q;
    logic [WD_W-1:0]       wd_q;
    logic [15:0]           err_cnt_q;

    logic                  setup_req;
    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_idx;
    logic                  slv_ready;
    logic                  slv_err;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic [NB_SLAVES-1:0]  sel_onehot;
    logic                  wd_hit;
    logic                  node_err;

    assign setup_req = psel_i && !penable_i;
    assign wd_hit    = WD_EN && (wd_q == WD_LAST);

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NB_SLAVES - 1; k >= 0; k--) begin
            if ((paddr_i >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (paddr_i <= END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        slv_ready  = 1'b0;
        slv_err    = 1'b0;
        slv_rdata  = '0;
        sel_onehot = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                slv_ready     = pready_i[k];
                slv_err       = pslverr_i[k];
                slv_rdata     = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // A slave ready in the watchdog's last cycle takes priority over the abort.
    assign node_err = ((state == ST_IDLE) && setup_req && !dec_hit) ||
                      ((state == ST_ACCESS) && !slv_ready && wd_hit);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (setup_req) state_nxt = dec_hit ? ST_SETUP : ST_DONE;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (slv_ready || wd_hit) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        psel_o    = '0;
        penable_o = 1'b0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        case (state)
            ST_SETUP: psel_o = sel_onehot;
            ST_ACCESS: begin
                psel_o    = sel_onehot;
                penable_o = 1'b1;
            end
            ST_DONE: begin
                pready_o  = 1'b1;
                pslverr_o = err_q;
                prdata_o  = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (setup_req) begin
                        addr_q  <= paddr_i;
                        wdata_q <= pwdata_i;
                        write_q <= pwrite_i;
                        idx_q   <= dec_idx;
                        wd_q    <= '0;
                        err_q   <= !dec_hit;
                        rdata_q <= dec_hit ? '0 : ERR_RDATA;
                    end
                end
                ST_ACCESS: begin
                    if (slv_ready) begin
                        rdata_q <= slv_rdata;
                        err_q   <= slv_err;
                    end else if (wd_hit) begin
                        rdata_q   <= ERR_RDATA;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn)                             err_cnt_q <= '0;
        else if (node_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pwrite_o  = write_q;
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_cnt_q;

endmodule
